npcg_toggle_pm_cal_issuer: RTL and testbench

Primitive-manager stage directly downstream of the NPCG_Toggle blocking-command modules. It accepts a CAL (command/address latch) primitive on the PM interface, consumes the command/address bytes over a valid/ready handshake, and drives them onto the Toggle NAND bus with programmable WE# pulse timing. Completion is reported with a one-cycle last-step strobe.

---
 rtl/npcg_toggle_pm_cal_issuer.sv | 186 ++++++++++++++++++
 tb/tb_npcg_toggle_pm_cal_issuer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npcg_toggle_pm_cal_issuer.sv
// CAL primitive issuer: takes command/address bytes from the PM side over a
// valid/ready handshake and drives them onto the Toggle NAND bus with programmable WE# timing.
module npcg_toggle_pm_cal_issuer #(
    parameter int NumberOfWays  = 4,
    parameter int WEPulseCycles = 2,
    parameter int WEHoldCycles  = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [7:0]              iPM_PCommand,
    input  logic [NumberOfWays-1:0] iPM_TargetWay,
    input  logic [15:0]             iPM_NumOfData,
    input  logic                    iPM_CASelect,
    input  logic [7:0]              iPM_CAData,
    input  logic                    iPM_CAValid,
    output logic                    oPM_CAReady,
    output logic                    oPM_Ready,
    output logic                    oPM_LastStep,
    output logic [NumberOfWays-1:0] oNAND_CE_n,
    output logic                    oNAND_CLE,
    output logic                    oNAND_ALE,
    output logic                    oNAND_WE_n,
    output logic [7:0]              oNAND_DQ,
    output logic                    oNAND_DQ_OE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_CA = 3'd1;
    localparam logic [2:0] S_WE_LOW  = 3'd2;
    localparam logic [2:0] S_WE_HIGH = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] LowLoad  = 4'(WEPulseCycles - 1);
    localparam logic [3:0] HighLoad = 4'(WEHoldCycles - 1);
    localparam logic [NumberOfWays-1:0] AllOnes = {NumberOfWays{1'b1}};

    logic [2:0]              state_q, state_d;
    logic [NumberOfWays-1:0] way_q, way_d;
    logic [3:0]              count_q, count_d;
    logic [3:0]              timer_q, timer_d;
    logic                    ready_q, ready_d;
    logic                    ca_ready_q, ca_ready_d;
    logic                    last_q, last_d;
    logic [NumberOfWays-1:0] ce_n_q, ce_n_d;
    logic                    cle_q, cle_d;
    logic                    ale_q, ale_d;
    logic                    we_n_q, we_n_d;
    logic [7:0]              dq_q, dq_d;
    logic                    dq_oe_q, dq_oe_d;

    // Next-state and next-output decode; every output is registered so it follows the state it belongs to.
    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        count_d    = count_q;
        timer_d    = timer_q;
        ready_d    = ready_q;
        ca_ready_d = ca_ready_q;
        last_d     = 1'b0;
        ce_n_d     = ce_n_q;
        cle_d      = cle_q;
        ale_d      = ale_q;
        we_n_d     = we_n_q;
        dq_d       = dq_q;
        dq_oe_d    = dq_oe_q;
        case (state_q)
            S_IDLE: begin
                if (iPM_PCommand[3]) begin
                    way_d   = iPM_TargetWay;
                    count_d = iPM_NumOfData[3:0];
                    ready_d = 1'b0;
                    // An empty way mask completes without touching the bus.
                    if (iPM_TargetWay == {NumberOfWays{1'b0}}) begin
                        state_d = S_DONE;
                        last_d  = 1'b1;
                    end else begin
                        state_d    = S_WAIT_CA;
                        ca_ready_d = 1'b1;
                        ce_n_d     = ~iPM_TargetWay;
                        dq_oe_d    = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_WAIT_CA: begin
                if (iPM_CAValid) begin
                    dq_d       = iPM_CAData;
                    cle_d      = ~iPM_CASelect;
                    ale_d      = iPM_CASelect;
                    we_n_d     = 1'b0;
                    timer_d    = LowLoad;
                    ca_ready_d = 1'b0;
                    state_d    = S_WE_LOW;
                end else begin
                    ca_ready_d = 1'b1;
                end
            end
            S_WE_LOW: begin
                if (timer_q == 4'd0) begin
                    we_n_d  = 1'b1;
                    timer_d = HighLoad;
                    state_d = S_WE_HIGH;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            S_WE_HIGH: begin
                if (timer_q == 4'd0) begin
                    if (count_q == 4'd0) begin
                        state_d = S_DONE;
                        last_d  = 1'b1;
                        ce_n_d  = AllOnes;
                        cle_d   = 1'b0;
                        ale_d   = 1'b0;
                        dq_oe_d = 1'b0;
                    end else begin
                        count_d    = count_q - 4'd1;
                        ca_ready_d = 1'b1;
                        state_d    = S_WAIT_CA;
                    end
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d    = S_IDLE;
                ready_d    = 1'b1;
                ca_ready_d = 1'b0;
                ce_n_d     = AllOnes;
                cle_d      = 1'b0;
                ale_d      = 1'b0;
                we_n_d     = 1'b1;
                dq_oe_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge iSystemClock or negedge iReset) begin
        if (!iReset) begin
            state_q    <= S_IDLE;
            way_q      <= {NumberOfWays{1'b0}};
            count_q    <= 4'd0;
            timer_q    <= 4'd0;
            ready_q    <= 1'b1;
            ca_ready_q <= 1'b0;
            last_q     <= 1'b0;
            ce_n_q     <= AllOnes;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            we_n_q     <= 1'b1;
            dq_q       <= 8'h00;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            ready_q    <= ready_d;
            ca_ready_q <= ca_ready_d;
            last_q     <= last_d;
            ce_n_q     <= ce_n_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            we_n_q     <= we_n_d;
            dq_q       <= dq_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign oPM_CAReady  = ca_ready_q;
    assign oPM_Ready    = ready_q;
    assign oPM_LastStep = last_q;
    assign oNAND_CE_n   = ce_n_q;
    assign oNAND_CLE    = cle_q;
    assign oNAND_ALE    = ale_q;
    assign oNAND_WE_n   = we_n_q;
    assign oNAND_DQ     = dq_q;
    assign oNAND_DQ_OE  = dq_oe_q;

endmodule

// File: tb/tb_npcg_toggle_pm_cal_issuer.sv
// Bench for npcg_toggle_pm_cal_issuer: two instances (default timing and 1/3 timing), one active at a time,
// observed by a bus-level monitor that checks bytes, WE# timing and LastStep against an expected-byte queue.
module tb_npcg_toggle_pm_cal_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd;
    logic [3:0]  way_i;
    logic [15:0] nod;
    logic        casel;
    logic [7:0]  ca_data;
    logic        ca_valid;
    int          sel;

    logic       o_ca_ready [2];
    logic       o_ready    [2];
    logic       o_last     [2];
    logic [3:0] o_ce_n     [2];
    logic       o_cle      [2];
    logic       o_ale      [2];
    logic       o_we_n     [2];
    logic [7:0] o_dq       [2];
    logic       o_dq_oe    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        npcg_toggle_pm_cal_issuer #(
            .NumberOfWays (4),
            .WEPulseCycles(g == 0 ? 2 : 1),
            .WEHoldCycles (g == 0 ? 2 : 3)
        ) u_dut (
            .iSystemClock (clk),
            .iReset       (rst_n),
            .iPM_PCommand ((sel == g) ? cmd : 8'h00),
            .iPM_TargetWay(way_i),
            .iPM_NumOfData(nod),
            .iPM_CASelect (casel),
            .iPM_CAData   (ca_data),
            .iPM_CAValid  ((sel == g) ? ca_valid : 1'b0),
            .oPM_CAReady  (o_ca_ready[g]),
            .oPM_Ready    (o_ready[g]),
            .oPM_LastStep (o_last[g]),
            .oNAND_CE_n   (o_ce_n[g]),
            .oNAND_CLE    (o_cle[g]),
            .oNAND_ALE    (o_ale[g]),
            .oNAND_WE_n   (o_we_n[g]),
            .oNAND_DQ     (o_dq[g]),
            .oNAND_DQ_OE  (o_dq_oe[g])
        );
    end

    logic       cur_ca_ready, cur_ready, cur_last, cur_cle, cur_ale, cur_we_n, cur_dq_oe;
    logic [3:0] cur_ce_n;
    logic [7:0] cur_dq;
    assign cur_ca_ready = o_ca_ready[sel];
    assign cur_ready    = o_ready[sel];
    assign cur_last     = o_last[sel];
    assign cur_ce_n     = o_ce_n[sel];
    assign cur_cle      = o_cle[sel];
    assign cur_ale      = o_ale[sel];
    assign cur_we_n     = o_we_n[sel];
    assign cur_dq       = o_dq[sel];
    assign cur_dq_oe    = o_dq_oe[sel];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    // expected byte: {last_of_primitive, ce_n[3:0], cle, ale, dq[7:0]}
    logic [14:0] exp_q[$];
    int ls_exp_cycle = -1;
    int fall_cnt = 0;
    int last_fall_cyc = -1;
    logic [7:0] fix_b [16];
    logic       fix_cs[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Bus monitor: measures WE# low/high runs, checks each latched byte and the LastStep pulse.
    initial begin : monitor
        logic        prev_we, prev_ls;
        int          low_len, high_len, p, h;
        logic [14:0] e;
        logic [13:0] bus;
        prev_we = 1'b1; prev_ls = 1'b0; low_len = 0; high_len = 100; bus = 14'd0;
        forever begin
            @(negedge clk);
            p = (sel == 0) ? 2 : 1;
            h = (sel == 0) ? 2 : 3;
            if (!rst_n) begin
                prev_we = 1'b1; prev_ls = 1'b0; high_len = 100;
            end else begin
                check("last_step", cur_last, (cyc == ls_exp_cycle));
                if (prev_ls) check("ready_after_done", cur_ready, 1);
                if (!cur_we_n) begin
                    if (prev_we) begin
                        check("we_high_time", (high_len >= h), 1);
                        check("dq_oe_active", cur_dq_oe, 1);
                        low_len = 0;
                        fall_cnt++;
                        last_fall_cyc = cyc;
                    end
                    low_len++;
                    bus = {cur_ce_n, cur_cle, cur_ale, cur_dq};
                end else begin
                    if (!prev_we) begin
                        check("we_low_time", low_len, p);
                        if (exp_q.size() == 0) begin
                            check("byte_expected", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("byte_bus", bus, e[13:0]);
                            if (e[14]) ls_exp_cycle = cyc + h;
                        end
                        high_len = 0;
                    end
                    high_len++;
                end
                prev_we = cur_we_n;
                prev_ls = cur_last;
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!cur_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", cur_ready, 1);
    endtask

    task automatic wait_ca_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!cur_ca_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("ca_ready_timeout", cur_ca_ready, 1);
    endtask

    task automatic run_prim(input logic [3:0] way, input logic [3:0] n, input bit gap,
                            input bit poke, input bit use_fix);
        logic [31:0] r;
        logic [7:0]  b, b0;
        logic        cs;
        logic [3:0]  ce_exp;
        int          vcyc;
        ce_exp = ~way;
        b0 = 8'h00;
        wait_ready();
        @(posedge clk); #1;
        r = $urandom; cmd = r[7:0] | 8'h08;
        r = $urandom; nod = {r[15:4], n};
        way_i = way;
        if (way == 4'd0) ls_exp_cycle = cyc + 1;
        @(posedge clk); #1;
        r = $urandom; cmd = r[7:0] & 8'hF7;
        @(negedge clk);
        check("ready_busy", cur_ready, 0);
        if (way != 4'd0) begin
            for (int i = 0; i <= int'(n); i++) begin
                r = $urandom;
                b  = use_fix ? fix_b[i] : r[7:0];
                cs = use_fix ? fix_cs[i] : r[8];
                if (i == 0) b0 = b;
                exp_q.push_back({(i == int'(n)), ce_exp, ~cs, cs, b});
                if (gap && i == 1) begin
                    wait_ca_ready();
                    repeat (3) begin
                        check("gap_we_n", cur_we_n, 1);
                        check("gap_ce_n", cur_ce_n, ce_exp);
                        check("gap_dq", cur_dq, b0);
                        @(negedge clk);
                    end
                end else begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
                @(posedge clk); #1;
                ca_data = b; casel = cs; ca_valid = 1'b1;
                vcyc = cyc;
                wait_ca_ready();
                @(posedge clk); #1;
                ca_valid = 1'b0;
                r = $urandom; ca_data = r[7:0]; casel = r[8];
                if (poke && i == 0) begin
                    cmd = 8'h08;
                    @(posedge clk); #1;
                    cmd = 8'h00;
                end
                if (gap && i == 1) begin
                    @(negedge clk); #1;
                    check("gap_resume_cycle", last_fall_cyc, vcyc + 1);
                end
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] w;
        int start;
        rst_n = 1'b1; cmd = 8'h00; way_i = 4'd0; nod = 16'd0;
        casel = 1'b0; ca_data = 8'h00; ca_valid = 1'b0; sel = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", cur_ready, 1);
        check("rst_ca_ready", cur_ca_ready, 0);
        check("rst_last", cur_last, 0);
        check("rst_ce_n", cur_ce_n, 4'hF);
        check("rst_cle_ale", {cur_cle, cur_ale}, 2'b00);
        check("rst_we_n", cur_we_n, 1);
        check("rst_dq", cur_dq, 8'h00);
        check("rst_dq_oe", cur_dq_oe, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single command byte 0x70 on way 1
        fix_b[0] = 8'h70; fix_cs[0] = 1'b0;
        run_prim(4'b0010, 4'd0, 1'b0, 1'b0, 1'b1);
        // five-byte address burst
        fix_b[0] = 8'h00; fix_b[1] = 8'h00; fix_b[2] = 8'h05; fix_b[3] = 8'h01; fix_b[4] = 8'h00;
        for (int i = 0; i < 5; i++) fix_cs[i] = 1'b1;
        run_prim(4'b0001, 4'd4, 1'b0, 1'b0, 1'b1);
        // valid gap between bytes 1 and 2
        run_prim(4'b1000, 4'd3, 1'b1, 1'b0, 1'b0);
        // CAL request while busy must not start a second primitive
        run_prim(4'b0100, 4'd1, 1'b0, 1'b1, 1'b0);
        wait_ready();
        repeat (4) @(negedge clk);
        check("no_second_prim", cur_ready, 1);
        // empty way mask
        run_prim(4'b0000, 4'd5, 1'b0, 1'b0, 1'b0);

        // async reset during the second WE# low of a three-byte primitive
        wait_ready();
        @(posedge clk); #1;
        cmd = 8'h08; way_i = 4'b0100; nod = 16'h0002;
        @(posedge clk); #1;
        cmd = 8'h00;
        for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), 4'b1011, 1'b1, 1'b0, 8'hA5});
        ca_data = 8'hA5; casel = 1'b0; ca_valid = 1'b1;
        start = fall_cnt;
        for (int k = 0; k < 400 && fall_cnt < start + 2; k++) begin
            @(negedge clk); #1;
        end
        check("second_pulse_seen", fall_cnt, start + 2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_we_n", cur_we_n, 1);
        check("arst_ce_n", cur_ce_n, 4'hF);
        check("arst_cle_ale", {cur_cle, cur_ale}, 2'b00);
        check("arst_dq_oe", cur_dq_oe, 0);
        check("arst_ready", cur_ready, 1);
        ca_valid = 1'b0;
        exp_q.delete();
        ls_exp_cycle = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // randomized primitives, default timing
        repeat (12) begin
            w = 4'(1 << $urandom_range(0, 3));
            run_prim(w, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        end

        // WE# low 1 / high 3 instance
        wait_ready();
        sel = 1;
        run_prim(4'b0010, 4'd15, 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            w = 4'(1 << $urandom_range(0, 3));
            run_prim(w, 4'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
        end

        wait_ready();
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
